// File: rtl/pt2272_pkg.sv
// Shared types and timing constants for the PT2272 receive-side decoder.
// Timing constants are in units of T (encoder oscillator periods).
package pt2272_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC_WAIT,
        BITS,
        SYNC_CHK
    } state_t;

    typedef enum logic [1:0] {
        ZERO,
        ONE,
        FLOAT,
        ERR
    } symbol_t;

    typedef enum logic [1:0] {
        PH_SHORT,
        PH_LONG,
        PH_SYNC,
        PH_ERR
    } phase_t;

    localparam int SHORT_MIN  = 2;
    localparam int LONG_MIN   = 8;
    localparam int LONG_MAX   = 20;
    localparam int SYNC_MIN   = 64;
    localparam int VT_TIMEOUT = 1024;

    localparam int WORD_W = 12;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;
    localparam int PAIRS  = 2 * WORD_W;
    localparam int CNT_W  = 12;

    // Two half-bits form one symbol; a '1' half followed by a '0' half is illegal.
    function automatic symbol_t sym_decode(input logic h0, input logic h1);
        symbol_t s;
        case ({h0, h1})
            2'b00:   s = ZERO;
            2'b11:   s = ONE;
            2'b01:   s = FLOAT;
            default: s = ERR;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pt2272_pulse_meas.sv
// Synchronizes cod_i, times each high/low phase with a saturating counter and
// classifies it; also strobes once when a low phase reaches the sync length.
module pt2272_pulse_meas
    import pt2272_pkg::*;
#(
    parameter int CYC = 16
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   cod_i,
    output logic   ph_vld,
    output logic   ph_lvl,
    output phase_t ph_cls,
    output logic   sync_stb
);

    localparam logic [CNT_W-1:0] SHORT_CYC = CNT_W'(SHORT_MIN * CYC);
    localparam logic [CNT_W-1:0] LONG_CYC  = CNT_W'(LONG_MIN * CYC);
    localparam logic [CNT_W-1:0] LMAX_CYC  = CNT_W'(LONG_MAX * CYC);
    localparam logic [CNT_W-1:0] SYNC_CYC  = CNT_W'(SYNC_MIN * CYC);
    localparam logic [CNT_W-1:0] LMAX_LAST = CNT_W'(LONG_MAX * CYC - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_MIN * CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             sync_p0;
    logic             sync_p1;
    logic             lvl;
    logic [CNT_W-1:0] cnt;
    logic             toggle;
    logic             hi_stuck;

    function automatic phase_t classify(input logic [CNT_W-1:0] width, input logic high);
        if (width < SHORT_CYC) return PH_ERR;
        if (width < LONG_CYC)  return PH_SHORT;
        if (width < LMAX_CYC)  return PH_LONG;
        if (!high && width >= SYNC_CYC) return PH_SYNC;
        return PH_ERR;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            lvl     <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= cod_i;
            sync_p1 <= sync_p0;
            lvl     <= sync_p1;
            if (toggle) begin
                cnt <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // cnt always holds the width of the phase at level lvl, so on a toggle it
    // is exactly the width of the phase that just ended.
    assign toggle   = sync_p1 ^ lvl;
    assign hi_stuck = lvl & ~toggle & (cnt == LMAX_LAST);
    assign sync_stb = ~lvl & ~toggle & (cnt == SYNC_LAST);
    assign ph_vld   = toggle | hi_stuck;
    assign ph_lvl   = lvl;

    always_comb begin
        ph_cls = classify(cnt, lvl);
        if (hi_stuck) ph_cls = PH_ERR;
    end

endmodule

// File: rtl/pt2272_decoder.sv
// PT2272 decoder: recovers 8 address + 4 data bits per word, confirms on two
// identical consecutive words. PT2272_MOMENTARY_EN clears D when vt times out.
module pt2272_decoder
    import pt2272_pkg::*;
#(
    parameter int CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cod_i,
    input  logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    output logic              vt
);

    localparam int              VT_CYC    = VT_TIMEOUT * CYC;
    localparam int              TMR_W     = $clog2(VT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(VT_CYC - 1);
    localparam logic [4:0]      PAIR_LAST = 5'(PAIRS - 1);

    logic   ph_vld;
    logic   ph_lvl;
    phase_t ph_cls;
    logic   sync_stb;

    state_t              state, state_nxt;
    logic [4:0]          pair, pair_nxt;
    logic                hi_long, hi_long_nxt;
    logic                half0, half0_nxt;
    logic                hi_ok, hi_ok_nxt;
    logic [WORD_W-1:0]   word, word_nxt;
    logic [WORD_W-1:0]   flt, flt_nxt;
    logic [WORD_W-1:0]   prev_word, prev_word_nxt;
    logic                prev_vld, prev_vld_nxt;
    logic [DATA_W-1:0]   d_nxt;
    logic                vt_nxt;
    logic [TMR_W-1:0]    tmr, tmr_nxt;

    logic    lo_long;
    logic    half;
    logic    pair_err;
    logic    addr_ok;
    symbol_t sym;

    pt2272_pulse_meas #(
        .CYC(CYC)
    ) u_meas (
        .clk     (clk),
        .reset   (reset),
        .cod_i   (cod_i),
        .ph_vld  (ph_vld),
        .ph_lvl  (ph_lvl),
        .ph_cls  (ph_cls),
        .sync_stb(sync_stb)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pair      <= '0;
            hi_long   <= 1'b0;
            half0     <= 1'b0;
            hi_ok     <= 1'b0;
            word      <= '0;
            flt       <= '0;
            prev_word <= '0;
            prev_vld  <= 1'b0;
            D         <= '0;
            vt        <= 1'b0;
            tmr       <= '0;
        end else begin
            state     <= state_nxt;
            pair      <= pair_nxt;
            hi_long   <= hi_long_nxt;
            half0     <= half0_nxt;
            hi_ok     <= hi_ok_nxt;
            word      <= word_nxt;
            flt       <= flt_nxt;
            prev_word <= prev_word_nxt;
            prev_vld  <= prev_vld_nxt;
            D         <= d_nxt;
            vt        <= vt_nxt;
            tmr       <= tmr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pair_nxt      = pair;
        hi_long_nxt   = hi_long;
        half0_nxt     = half0;
        hi_ok_nxt     = hi_ok;
        word_nxt      = word;
        flt_nxt       = flt;
        prev_word_nxt = prev_word;
        prev_vld_nxt  = prev_vld;
        d_nxt         = D;
        vt_nxt        = vt;
        tmr_nxt       = tmr;

        lo_long  = (ph_cls == PH_LONG);
        half     = hi_long;          // long high + short low is a '1' half
        sym      = sym_decode(half0, half);
        pair_err = 1'b0;
        addr_ok  = (word[WORD_W-1 -: ADDR_W] == A) && (flt == '0);

        if (vt) begin
            if (tmr == TMR_LAST) begin
                vt_nxt  = 1'b0;
                tmr_nxt = '0;
`ifdef PT2272_MOMENTARY_EN
                d_nxt   = '0;
`endif
            end else begin
                tmr_nxt = tmr + TMR_W'(1);
            end
        end

        case (state)
            IDLE: begin
                if (sync_stb) state_nxt = SYNC_WAIT;
            end

            SYNC_WAIT: begin
                if (ph_vld && !ph_lvl) begin
                    state_nxt = BITS;
                    pair_nxt  = '0;
                end
            end

            BITS: begin
                if (sync_stb) begin
                    state_nxt = SYNC_WAIT;
                end else if (ph_vld) begin
                    if (ph_cls != PH_SHORT && ph_cls != PH_LONG) begin
                        pair_err = 1'b1;
                    end else if (ph_lvl) begin
                        hi_long_nxt = (ph_cls == PH_LONG);
                    end else if (lo_long == hi_long) begin
                        pair_err = 1'b1;
                    end else begin
                        if (!pair[0]) begin
                            half0_nxt = half;
                        end else if (sym == ERR) begin
                            pair_err = 1'b1;
                        end else begin
                            word_nxt = {word[WORD_W-2:0], sym == ONE};
                            flt_nxt  = {flt[WORD_W-2:0], sym == FLOAT};
                        end
                        pair_nxt = pair + 5'd1;
                        if (pair == PAIR_LAST) begin
                            state_nxt = SYNC_CHK;
                            hi_ok_nxt = 1'b0;
                        end
                    end
                    if (pair_err) state_nxt = IDLE;
                end
            end

            SYNC_CHK: begin
                if (ph_vld) begin
                    if (ph_lvl && ph_cls == PH_SHORT && !hi_ok) hi_ok_nxt = 1'b1;
                    else state_nxt = IDLE;
                end else if (sync_stb && hi_ok) begin
                    state_nxt = SYNC_WAIT;
                    // A confirm here overrides a timeout decided above.
                    if (addr_ok) begin
                        if (prev_vld && prev_word == word) begin
                            d_nxt   = word[DATA_W-1:0];
                            vt_nxt  = 1'b1;
                            tmr_nxt = '0;
                        end
                        prev_word_nxt = word;
                        prev_vld_nxt  = 1'b1;
                    end else begin
                        prev_vld_nxt = 1'b0;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/pt2272_decoder.md
# pt2272_decoder

Serial remote-control decoder, receive side of the PT2262 link: samples the single-wire `cod_i` stream from the encoder, measures pulse widths against a tick-based time base, and recovers 8 address bits plus 4 data bits per word. A word is accepted only when its address equals the local `A` setting and two consecutive words are identical; the data nibble is then presented on `D` and `vt` is asserted. The block sits between the RF/serial input pin and the application logic.

## Interface
- `CYC`, 16: `clk` cycles per timing unit T; the encoder oscillator period.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `cod_i`  in  1  serial code input, asynchronous to `clk`
- `A`  in  8  local address; quasi-static
- `D`  out  4  decoded data nibble
- `vt`  out  1  valid transmission flag

## Operation
- Frame format, units of T:
  - bit '0' = 4H 12L 4H 12L
  - bit '1' = 12H 4L 12H 4L
  - bit 'F' = 4H 12L 12H 4L
  - sync = 4H 124L
- Word = 12 bits, sent A[7]..A[0] then D[3]..D[0], followed by sync.
- `cod_i` passes through a 2-flop synchronizer; a 12-bit saturating counter measures each high and low phase in `clk` cycles.
- Phase classification:
  - short: [2T, 8T)
  - long: [8T, 20T)
  - sync low: ≥ 64T
  - anything else is an error: glitch < 2T, or 20T ≤ width < 64T other than a sync low.
- One pulse pair (high phase then low phase) forms one half-bit:
  - short/long = half '0'
  - long/short = half '1'
  - short/short and long/long are errors
- Two halves form one bit:
  - 0,0 → '0'
  - 1,1 → '1'
  - 0,1 → 'F', treated as an address/data mismatch
  - 1,0 → error
- FSM states:
  - IDLE → SYNC_WAIT when the low counter reaches 64T.
  - SYNC_WAIT → BITS on the first rising edge.
  - BITS decodes 24 pulse pairs. Any error → IDLE.
  - After 24 pairs → SYNC_CHK, which expects a short high then a low.
  - SYNC_CHK, when the low counter reaches 64T: evaluate the word, then → SYNC_WAIT. Short or long low → IDLE, word discarded.
- Word evaluation:
  - Address bits must equal `A` and contain no 'F'.
  - If the word matches the stored previous word, `D` is loaded, `vt` is set to 1, and the vt timer restarts.
  - Every address-valid word is stored as the previous word.
  - A mismatching or invalid word clears the stored-valid flag and leaves `D` and `vt` untouched.
- vt timeout: `vt` clears when 1024T elapse with no confirmed word.

## Timing
- Reset values: `D`=0, `vt`=0, FSM=IDLE, previous word invalid, counters 0.
- Latency: `D`/`vt` update on the same `clk` edge, `CYC*64 + 2` cycles after the falling edge that starts the confirming word's sync low.
- Continuous transmission: the first word only primes the compare; `vt` rises after the second word and stays high while identical words repeat.
- Data change mid-stream: the new value needs two consecutive identical words. Until then `D` holds its old value and `vt` stays high.
- Timeout vs confirm in the same cycle: the confirm wins.
- Counter saturation: a stuck-low line stays classified as a sync low; a stuck-high line is an error → IDLE.
- `reset` asserted mid-word: immediate async clear of all state and outputs. Decoding restarts from IDLE and needs a fresh sync.

## Configuration
- `PT2272_MOMENTARY_EN`
  - Defined: momentary (M4) behaviour. `D` clears to 0 in the same cycle `vt` times out.
  - Undefined: latched (L4) behaviour. `D` holds its last confirmed value after `vt` falls, until the next confirmation or reset.

## Structure
- `pt2272_pkg`:
  - state enum (IDLE, SYNC_WAIT, BITS, SYNC_CHK)
  - symbol enum (ZERO, ONE, FLOAT, ERR)
  - T-unit constants: SHORT_MIN=2, LONG_MIN=8, LONG_MAX=20, SYNC_MIN=64, VT_TIMEOUT=1024
  - word width 12
- Sub-module `pt2272_pulse_meas`: synchronizer, edge detect, phase counter, and short/long/sync/err classification. Reports one result per completed phase, plus a sync strobe raised at the 64T threshold.

## Test plan
- `A`=8'hF0; two words A=F0, D=4'b1010, CYC=16 → `vt`=1 and `D`=4'b1010 2+1024 cycles into the second sync; `D`=0/`vt`=0 after the first word only.
- Same stream with `A`=8'hF1 → `vt` stays 0, `D` stays 0.
- Confirmed D=4'b1010, then two words with D=4'b0011 → `D` holds 1010 through the first word, becomes 0011 after the second; `vt` never drops.
- Stop transmitting after confirmation → `vt` falls 1024T after the last confirm. `D` stays 1010 without `PT2272_MOMENTARY_EN`, clears to 0 with it.
- Inject a 1T glitch into bit 5 of a word → word discarded, FSM returns to IDLE, the next two clean words confirm normally.
- Assert `reset` low mid-word while `vt`=1 → `D`=0 and `vt`=0 immediately; recovery needs two full words after release.
